// File: rtl/display_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// display_scheduler_pkg
// Shared definitions for the display ownership scheduler: FSM state
// encoding, number of request sources, default timing constants and the
// result type of the round-robin pick.
// ---------------------------------------------------------------------------
package display_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int NREQ             = 4;
    localparam int DEFAULT_PRESCALE = 50000;
    localparam int DEFAULT_HOLD     = 256;

    // Number of scan ticks the display stays blanked between owners when
    // the blanking gap is built in.
    localparam int GAP_TICKS = 2;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } pick_t;

endpackage

// File: rtl/scan_tick_gen.sv
// ---------------------------------------------------------------------------
// scan_tick_gen
// Free-running prescaler producing a one-Clk-wide scan tick every PRESCALE
// cycles. Reusable by any display block that needs the refresh cadence.
//
// Ports:
//   Clk  in   system clock, rising edge
//   Rst  in   asynchronous active-high reset (counter to 0, Cen low)
//   Cen  out  high for the single cycle the count equals PRESCALE-1
// ---------------------------------------------------------------------------
module scan_tick_gen
    import display_scheduler_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic Clk,
    input  logic Rst,
    output logic Cen
);

    localparam int            CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Decoded straight from the counter, so it drops to 0 as soon as Rst
    // clears the count.
    assign Cen = (cnt == LAST);

endmodule

// File: rtl/display_scheduler.sv
// ---------------------------------------------------------------------------
// display_scheduler
// Round-robin arbiter handing a shared 2-digit display to one of four
// sources for HOLD scan ticks at a time. The owner's byte is passed through
// combinationally to the digit-refresh multiplexer.
//
// Ports:
//   Clk          in   system clock, rising edge
//   Rst          in   asynchronous active-high reset
//   Req[3:0]     in   level-sensitive display requests, one per source
//   Data0..Data3 in   byte each source wants shown
//   Gnt[3:0]     out  one-hot grant of the current owner, or all zero
//   Src[1:0]     out  index of the current or last owner
//   DispD[7:0]   out  byte to the digit-refresh multiplexer
//   Cen          out  one-Clk-wide scan tick
//   Blank        out  display blanking indication
//
// Build option DISP_BLANK_GAP_EN: when defined, every hand-over to a
// different owner (or to idle) blanks the display for GAP_TICKS scan ticks
// before arbitrating again. Re-granting the same owner skips the gap.
// ---------------------------------------------------------------------------
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int HOLD     = DEFAULT_HOLD
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [NREQ-1:0] Req,
    input  logic [7:0]      Data0,
    input  logic [7:0]      Data1,
    input  logic [7:0]      Data2,
    input  logic [7:0]      Data3,
    output logic [NREQ-1:0] Gnt,
    output logic [1:0]      Src,
    output logic [7:0]      DispD,
    output logic            Cen,
    output logic            Blank
);

    localparam logic [15:0] SLOT_LAST = 16'(HOLD - 1);

    state_t      state_q, state_d;
    logic [1:0]  src_q, src_d;
    logic [15:0] slot_q, slot_d;     // scan ticks spent in OWN (or GAP)
    logic        have_q, have_d;     // an owner has existed since reset
    pick_t       pick;
    logic        expire;

    scan_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .Clk (Clk),
        .Rst (Rst),
        .Cen (Cen)
    );

    // Round-robin search starting one past the last owner, so the current
    // owner is checked last and only re-wins when nobody else asks.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req,
                                      input logic            from_zero,
                                      input logic [1:0]      last);
        pick_t      p;
        logic [1:0] start;
        logic [1:0] idx;
        p     = '0;
        start = from_zero ? 2'd0 : last + 2'd1;
        for (int i = 0; i < NREQ; i++) begin
            idx = start + 2'(i);
            if (!p.valid && req[idx]) begin
                p.valid = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    assign pick   = rr_pick(Req, !have_q, src_q);
    assign expire = Cen && (slot_q == SLOT_LAST);

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        slot_d  = slot_q;
        have_d  = have_q;

        case (state_q)
            ST_IDLE: begin
                slot_d = '0;
                if (pick.valid) begin
                    state_d = ST_OWN;
                    src_d   = pick.idx;
                    have_d  = 1'b1;
                end
            end

            ST_OWN: begin
                if (Cen) begin
                    slot_d = slot_q + 16'd1;
                end
                if (expire) begin
                    slot_d = '0;
                    if (pick.valid && pick.idx == src_q) begin
                        state_d = ST_OWN;          // sole requester keeps it
                    end else begin
`ifdef DISP_BLANK_GAP_EN
                        state_d = ST_GAP;
`else
                        if (pick.valid) begin
                            src_d = pick.idx;
                        end else begin
                            state_d = ST_IDLE;
                        end
`endif
                    end
                end else if (!Req[src_q]) begin
                    // Early release always drops the grant for at least one
                    // cycle; the next owner is chosen from IDLE or GAP.
                    slot_d = '0;
`ifdef DISP_BLANK_GAP_EN
                    state_d = ST_GAP;
`else
                    state_d = ST_IDLE;
`endif
                end
            end

`ifdef DISP_BLANK_GAP_EN
            ST_GAP: begin
                if (Cen) begin
                    if (slot_q == 16'(GAP_TICKS - 1)) begin
                        slot_d = '0;
                        if (pick.valid) begin
                            state_d = ST_OWN;
                            src_d   = pick.idx;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        slot_d = slot_q + 16'd1;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            src_q   <= 2'd0;
            slot_q  <= '0;
            have_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            slot_q  <= slot_d;
            have_q  <= have_d;
        end
    end

    // Outputs decode registered state; DispD follows the owner's data
    // combinationally.
    always_comb begin
        Gnt   = '0;
        DispD = 8'h00;
        Blank = 1'b1;
        if (state_q == ST_OWN) begin
            Gnt[src_q] = 1'b1;
            Blank      = 1'b0;
            case (src_q)
                2'd0:    DispD = Data0;
                2'd1:    DispD = Data1;
                2'd2:    DispD = Data2;
                default: DispD = Data3;
            endcase
        end
    end

    assign Src = src_q;

endmodule

// File: tb/tb_display_scheduler.sv
// ---------------------------------------------------------------------------
// tb_display_scheduler
// Directed bench for display_scheduler with PRESCALE=4, HOLD=2. Outputs are
// sampled on the falling edge. Expected scan ticks come from a cycle count
// kept by the bench: a tick is visible in the cycle after the 3rd, 7th,
// 11th ... rising edge following reset.
// ---------------------------------------------------------------------------
module tb_display_scheduler;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] Req;
    logic [7:0] Data0, Data1, Data2, Data3;
    logic [3:0] Gnt;
    logic [1:0] Src;
    logic [7:0] DispD;
    logic       Cen;
    logic       Blank;

    int checks   = 0;
    int failures = 0;
    int cyc;

    display_scheduler #(
        .PRESCALE (4),
        .HOLD     (2)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Req   (Req),
        .Data0 (Data0),
        .Data1 (Data1),
        .Data2 (Data2),
        .Data3 (Data3),
        .Gnt   (Gnt),
        .Src   (Src),
        .DispD (DispD),
        .Cen   (Cen),
        .Blank (Blank)
    );

    always #5 Clk = ~Clk;

    // Rising edges since reset released.
    always @(posedge Clk or posedge Rst) begin
        if (Rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g,
                              input logic [7:0] d, input logic [1:0] s,
                              input logic b);
        check({tag, "_gnt"},   32'(Gnt),   32'(g));
        check({tag, "_dispd"}, 32'(DispD), 32'(d));
        check({tag, "_src"},   32'(Src),   32'(s));
        check({tag, "_blank"}, 32'(Blank), 32'(b));
        check({tag, "_cen"},   32'(Cen),   32'((cyc % 4) == 3));
    endtask

    task automatic pulse_reset();
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    initial begin
        logic [3:0] eg;
        logic [7:0] ed;
        logic [1:0] es;
        logic       eb;

        Rst   = 1'b1;
        Req   = 4'b0000;
        Data0 = 8'h12;
        Data1 = 8'h56;
        Data2 = 8'h34;
        Data3 = 8'h78;

        // Reset values
        @(negedge Clk);
        check_outs("reset", 4'b0000, 8'h00, 2'd0, 1'b1);
        @(negedge Clk);
        Rst = 1'b0;

        // Idle, no requests: tick every 4th cycle, display blanked
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            check_outs("idle", 4'b0000, 8'h00, 2'd0, 1'b1);
        end

        // Sources 0 and 2 alternate every 2 ticks; first grant searches from 0
        Req = 4'b0101;
        for (int k = 9; k <= 31; k++) begin
            @(negedge Clk);
`ifdef DISP_BLANK_GAP_EN
            if (k < 16)      begin eg = 4'b0001; ed = 8'h12; es = 2'd0; eb = 1'b0; end
            else if (k < 24) begin eg = 4'b0000; ed = 8'h00; es = 2'd0; eb = 1'b1; end
            else             begin eg = 4'b0100; ed = 8'h34; es = 2'd2; eb = 1'b0; end
`else
            if (k < 16)      begin eg = 4'b0001; ed = 8'h12; es = 2'd0; eb = 1'b0; end
            else if (k < 24) begin eg = 4'b0100; ed = 8'h34; es = 2'd2; eb = 1'b0; end
            else             begin eg = 4'b0001; ed = 8'h12; es = 2'd0; eb = 1'b0; end
`endif
            check_outs("rr", eg, ed, es, eb);
        end

        // Reset mid-slot: outputs go to reset values at once
        Rst = 1'b1;
        #1;
        check_outs("rst_async", 4'b0000, 8'h00, 2'd0, 1'b1);
        @(negedge Clk);
        check_outs("rst_hold", 4'b0000, 8'h00, 2'd0, 1'b1);
        Rst = 1'b0;
        @(negedge Clk);
        check_outs("rst_regrant", 4'b0001, 8'h12, 2'd0, 1'b0);

        // Sole requester keeps the display across slot expiry, never blanks
        Req = 4'b0010;
        pulse_reset();
        for (int k = 1; k <= 16; k++) begin
            @(negedge Clk);
            check_outs("sole", 4'b0010, 8'h56, 2'd1, 1'b0);
        end

        // Owner 0 releases early while source 3 is waiting
        Req = 4'b1001;
        pulse_reset();
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            check_outs("rel_own", 4'b0001, 8'h12, 2'd0, 1'b0);
        end
        Req = 4'b1000;
        for (int k = 6; k <= 14; k++) begin
            @(negedge Clk);
`ifdef DISP_BLANK_GAP_EN
            if (k <= 11) begin eg = 4'b0000; ed = 8'h00; es = 2'd0; eb = 1'b1; end
            else         begin eg = 4'b1000; ed = 8'h78; es = 2'd3; eb = 1'b0; end
`else
            if (k == 6)  begin eg = 4'b0000; ed = 8'h00; es = 2'd0; eb = 1'b1; end
            else         begin eg = 4'b1000; ed = 8'h78; es = 2'd3; eb = 1'b0; end
`endif
            check_outs("release", eg, ed, es, eb);
        end

        // One-cycle request from source 1 while 0 owns is not remembered
        Req = 4'b0001;
        pulse_reset();
        for (int k = 1; k <= 16; k++) begin
            @(negedge Clk);
            check_outs("no_queue", 4'b0001, 8'h12, 2'd0, 1'b0);
            if (k == 4) Req = 4'b0011;
            if (k == 5) Req = 4'b0001;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
